// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline control stage.
//   stall_state_t : stall/flush sequencer states
//   NOP_NONE      : hazard-request value meaning "no hazard"
//   pipe_ctrl_t   : bundle of the six pipeline-register control signals
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN,
        LOAD_HOLD,
        BRANCH_FLUSH,
        MEM_WAIT
    } stall_state_t;

    localparam logic [1:0] NOP_NONE = 2'b00;

    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic bubble_execute;
        logic flush_decode;
        logic stall_execute;
        logic stall_memory;
    } pipe_ctrl_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter: sticks at all-ones, never wraps.
//   clk   : clock
//   rst   : synchronous active-high reset, clears value
//   inc   : count this cycle
//   value : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {CNT_W{1'b1}})) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller sitting behind the hazard detection unit.
// Control outputs are combinational from state and current inputs so hazards
// are honoured in the cycle they are flagged; state and counters are registered.
//   clk, rst             : clock, synchronous active-high reset
//   nop                  : hazard request (nonzero = hazard)
//   branch_taken_execute : taken branch resolved in execute
//   memory_busy          : data memory access not complete
//   pc_write_enable      : PC may update
//   stall_* / bubble_execute / flush_decode : pipeline register controls
//   stall_cycle_count    : saturating count of stall_fetch cycles
//   flush_cycle_count    : saturating count of flush_decode cycles
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES   = 1,
    parameter int unsigned BRANCH_FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W               = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       nop,
    input  logic             branch_taken_execute,
    input  logic             memory_busy,
    output logic             pc_write_enable,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             bubble_execute,
    output logic             flush_decode,
    output logic             stall_execute,
    output logic             stall_memory,
    output logic [CNT_W-1:0] stall_cycle_count,
    output logic [CNT_W-1:0] flush_cycle_count
);

    localparam int unsigned REM_W = $clog2(max_u(LOAD_STALL_CYCLES, BRANCH_FLUSH_CYCLES)) + 1;

    stall_state_t state_q, state_d;
    stall_state_t ret_q, ret_d;    // state to resume once memory is no longer busy
    logic [REM_W-1:0] rem_q, rem_d;
    stall_state_t eff_state;
    pipe_ctrl_t ctrl;

    // MEM_WAIT with memory released acts as the state it interrupted.
    assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        ret_d   = ret_q;
        rem_d   = rem_q;
        if (rst) begin
            ctrl = '0;
        end else if (memory_busy) begin
            ctrl.stall_fetch   = 1'b1;
            ctrl.stall_decode  = 1'b1;
            ctrl.stall_execute = 1'b1;
            ctrl.stall_memory  = 1'b1;
            state_d            = MEM_WAIT;
            // Only capture on entry so back-to-back busy cycles keep the original state.
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end
        end else if (branch_taken_execute) begin
            ctrl.flush_decode   = 1'b1;
            ctrl.bubble_execute = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                rem_d   = REM_W'(BRANCH_FLUSH_CYCLES - 1);
                state_d = BRANCH_FLUSH;
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = eff_state;
            case (eff_state)
                BRANCH_FLUSH: begin
                    ctrl.flush_decode   = 1'b1;
                    ctrl.bubble_execute = 1'b1;
                    rem_d               = rem_q - REM_W'(1);
                    if (rem_q <= REM_W'(1)) begin
                        state_d = RUN;
                    end
                end
                LOAD_HOLD: begin
                    ctrl.stall_fetch    = 1'b1;
                    ctrl.stall_decode   = 1'b1;
                    ctrl.bubble_execute = 1'b1;
                    rem_d               = rem_q - REM_W'(1);
                    if (rem_q <= REM_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (nop != NOP_NONE) begin
                        ctrl.stall_fetch    = 1'b1;
                        ctrl.stall_decode   = 1'b1;
                        ctrl.bubble_execute = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
                            state_d = LOAD_HOLD;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
        end
    end

    assign stall_fetch     = ctrl.stall_fetch;
    assign stall_decode    = ctrl.stall_decode;
    assign bubble_execute  = ctrl.bubble_execute;
    assign flush_decode    = ctrl.flush_decode;
    assign stall_execute   = ctrl.stall_execute;
    assign stall_memory    = ctrl.stall_memory;
    assign pc_write_enable = !rst && !ctrl.stall_fetch;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.stall_fetch),
        .value (stall_cycle_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.flush_decode),
        .value (flush_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: three controller instances share one stimulus stream.
//   dut_a : LOAD=1, BRANCH=2, CNT_W=16
//   dut_b : LOAD=3, BRANCH=2, CNT_W=16
//   dut_c : LOAD=1, BRANCH=2, CNT_W=4 (counter saturation)
// Control vectors are {pc_write_enable, stall_fetch, stall_decode,
// bubble_execute, flush_decode, stall_execute, stall_memory}.
module tb_pipeline_stall_controller;

    localparam logic [31:0] CTL_ZERO  = 32'b0000000;
    localparam logic [31:0] CTL_IDLE  = 32'b1000000;
    localparam logic [31:0] CTL_STALL = 32'b0111000;
    localparam logic [31:0] CTL_FLUSH = 32'b1001100;
    localparam logic [31:0] CTL_MEMST = 32'b0110011;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] nop;
    logic       br;
    logic       mb;

    int n_checks = 0;
    int n_errors = 0;

    logic        pcwe_a, sf_a, sd_a, be_a, fd_a, se_a, sm_a;
    logic        pcwe_b, sf_b, sd_b, be_b, fd_b, se_b, sm_b;
    logic        pcwe_c, sf_c, sd_c, be_c, fd_c, se_c, sm_c;
    logic [15:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
    logic [3:0]  scnt_c, fcnt_c;
    logic [31:0] ctl_a, ctl_b, ctl_c;

    assign ctl_a = {25'b0, pcwe_a, sf_a, sd_a, be_a, fd_a, se_a, sm_a};
    assign ctl_b = {25'b0, pcwe_b, sf_b, sd_b, be_b, fd_b, se_b, sm_b};
    assign ctl_c = {25'b0, pcwe_c, sf_c, sd_c, be_c, fd_c, se_c, sm_c};

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .LOAD_STALL_CYCLES   (1),
        .BRANCH_FLUSH_CYCLES (2),
        .CNT_W               (16)
    ) dut_a (
        .clk                  (clk),
        .rst                  (rst),
        .nop                  (nop),
        .branch_taken_execute (br),
        .memory_busy          (mb),
        .pc_write_enable      (pcwe_a),
        .stall_fetch          (sf_a),
        .stall_decode         (sd_a),
        .bubble_execute       (be_a),
        .flush_decode         (fd_a),
        .stall_execute        (se_a),
        .stall_memory         (sm_a),
        .stall_cycle_count    (scnt_a),
        .flush_cycle_count    (fcnt_a)
    );

    pipeline_stall_controller #(
        .LOAD_STALL_CYCLES   (3),
        .BRANCH_FLUSH_CYCLES (2),
        .CNT_W               (16)
    ) dut_b (
        .clk                  (clk),
        .rst                  (rst),
        .nop                  (nop),
        .branch_taken_execute (br),
        .memory_busy          (mb),
        .pc_write_enable      (pcwe_b),
        .stall_fetch          (sf_b),
        .stall_decode         (sd_b),
        .bubble_execute       (be_b),
        .flush_decode         (fd_b),
        .stall_execute        (se_b),
        .stall_memory         (sm_b),
        .stall_cycle_count    (scnt_b),
        .flush_cycle_count    (fcnt_b)
    );

    pipeline_stall_controller #(
        .LOAD_STALL_CYCLES   (1),
        .BRANCH_FLUSH_CYCLES (2),
        .CNT_W               (4)
    ) dut_c (
        .clk                  (clk),
        .rst                  (rst),
        .nop                  (nop),
        .branch_taken_execute (br),
        .memory_busy          (mb),
        .pc_write_enable      (pcwe_c),
        .stall_fetch          (sf_c),
        .stall_decode         (sd_c),
        .bubble_execute       (be_c),
        .flush_decode         (fd_c),
        .stall_execute        (se_c),
        .stall_memory         (sm_c),
        .stall_cycle_count    (scnt_c),
        .flush_cycle_count    (fcnt_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after an edge, then settle before checking.
    task automatic drive(input logic r, input logic [1:0] n, input logic b, input logic m);
        rst = r;
        nop = n;
        br  = b;
        mb  = m;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two edges with hazard and branch asserted.
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        check_eq("rst0_a", ctl_a, CTL_ZERO);
        check_eq("rst0_b", ctl_b, CTL_ZERO);
        step();
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        check_eq("rst1_a", ctl_a, CTL_ZERO);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("idle_a", ctl_a, CTL_IDLE);
        check_eq("idle_b", ctl_b, CTL_IDLE);
        check_eq("scnt0_a", 32'(scnt_a), 0);
        check_eq("fcnt0_a", 32'(fcnt_a), 0);
        step();

        // Single nop pulse: 1 stall cycle on a, 3 on b.
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        check_eq("ld1_c0_a", ctl_a, CTL_STALL);
        check_eq("ld3_c0_b", ctl_b, CTL_STALL);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("ld1_c1_a", ctl_a, CTL_IDLE);
        check_eq("ld1_scnt_a", 32'(scnt_a), 1);
        check_eq("ld3_c1_b", ctl_b, CTL_STALL);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("ld3_c2_b", ctl_b, CTL_STALL);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("ld3_c3_b", ctl_b, CTL_IDLE);
        check_eq("ld3_scnt_b", 32'(scnt_b), 3);
        step();

        // Second nop during the hold must not extend it.
        drive(1'b0, 2'b10, 1'b0, 1'b0);
        check_eq("ext_c0_b", ctl_b, CTL_STALL);
        step();
        drive(1'b0, 2'b11, 1'b0, 1'b0);
        check_eq("ext_c1_b", ctl_b, CTL_STALL);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("ext_c2_b", ctl_b, CTL_STALL);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("ext_c3_b", ctl_b, CTL_IDLE);
        check_eq("ext_scnt_b", 32'(scnt_b), 6);
        check_eq("ext_scnt_a", 32'(scnt_a), 3);
        step();

        // Branch pulse from RUN: two flush cycles, PC writes.
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        check_eq("br_c0_a", ctl_a, CTL_FLUSH);
        check_eq("br_c0_b", ctl_b, CTL_FLUSH);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("br_c1_a", ctl_a, CTL_FLUSH);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("br_c2_a", ctl_a, CTL_IDLE);
        check_eq("br_fcnt_a", 32'(fcnt_a), 2);
        check_eq("br_c2_b", ctl_b, CTL_IDLE);
        step();

        // Branch arriving in LOAD_HOLD cuts the stall short.
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        check_eq("brh_c0_b", ctl_b, CTL_STALL);
        step();
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        check_eq("brh_c1_b", ctl_b, CTL_FLUSH);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("brh_c2_b", ctl_b, CTL_FLUSH);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("brh_c3_b", ctl_b, CTL_IDLE);
        check_eq("brh_fcnt_b", 32'(fcnt_b), 4);
        check_eq("brh_scnt_b", 32'(scnt_b), 7);
        step();

        // memory_busy for 4 cycles inside BRANCH_FLUSH with one flush left.
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        check_eq("mw_c0_a", ctl_a, CTL_FLUSH);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 1) ? 2'b01 : 2'b00, 1'b0, 1'b1);
            check_eq("mw_busy_a", ctl_a, CTL_MEMST);
            step();
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("mw_c5_a", ctl_a, CTL_FLUSH);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("mw_c6_a", ctl_a, CTL_IDLE);
        check_eq("mw_scnt_a", 32'(scnt_a), 8);
        check_eq("mw_fcnt_a", 32'(fcnt_a), 6);
        step();

        // memory_busy outranks a simultaneous branch; branch is dropped.
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        check_eq("pri_c0_a", ctl_a, CTL_MEMST);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("pri_c1_a", ctl_a, CTL_IDLE);
        check_eq("pri_scnt_a", 32'(scnt_a), 9);
        step();

        // Reset during LOAD_HOLD aborts the hold and clears counters.
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        check_eq("mrst_c0_b", ctl_b, CTL_STALL);
        step();
        drive(1'b1, 2'b00, 1'b0, 1'b0);
        check_eq("mrst_c1_b", ctl_b, CTL_ZERO);
        check_eq("mrst_c1_c", ctl_c, CTL_ZERO);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("mrst_c2_b", ctl_b, CTL_IDLE);
        check_eq("mrst_scnt_b", 32'(scnt_b), 0);
        check_eq("mrst_scnt_c", 32'(scnt_c), 0);
        check_eq("mrst_fcnt_a", 32'(fcnt_a), 0);
        step();

        // nop held 20 cycles: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 2'b01, 1'b0, 1'b0);
            if (i == 0) check_eq("sat_ctl_c", ctl_c, CTL_STALL);
            if (i == 14) check_eq("sat_pre_c", 32'(scnt_c), 14);
            step();
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("sat_c", 32'(scnt_c), 15);
        check_eq("nosat_a", 32'(scnt_a), 20);
        check_eq("sat_idle_c", ctl_c, CTL_IDLE);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("sat_hold_c", 32'(scnt_c), 15);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
